// File: rtl/uart_mmio_pkg.sv
// Shared register map, load/store encodings and control bits for the UART MMIO block.
package uart_mmio_pkg;

  localparam logic [31:0] OFF_TX_RDY  = 32'h00;
  localparam logic [31:0] OFF_RX_VLD  = 32'h04;
  localparam logic [31:0] OFF_TX_DATA = 32'h08;
  localparam logic [31:0] OFF_RX_DATA = 32'h0C;
  localparam logic [31:0] OFF_STATUS  = 32'h10;
  localparam logic [31:0] OFF_CTRL    = 32'h14;

  typedef enum logic [2:0] {
    LsLb  = 3'b000,
    LsLh  = 3'b001,
    LsLw  = 3'b010,
    LsLbu = 3'b011,
    LsLhu = 3'b100,
    LsSb  = 3'b101,
    LsSh  = 3'b110,
    LsSw  = 3'b111
  } ld_st_e;

  localparam int unsigned CTRL_CLR_FLAGS = 0;
  localparam int unsigned CTRL_FLUSH_TX  = 1;
  localparam int unsigned CTRL_FLUSH_RX  = 2;

  function automatic logic is_store(logic [2:0] ctrl);
    return ctrl inside {LsSb, LsSh, LsSw};
  endfunction

endpackage

// File: rtl/uart_mmio_if.sv
// Memory-stage bus plus UART transmitter/receiver handshakes for the UART MMIO block.
interface uart_mmio_if;
  logic        acc_en;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  ld_st_ctrl;
  logic [31:0] rdata;
  logic [7:0]  uart_din;
  logic        uart_din_valid;
  logic        uart_din_ready;
  logic [7:0]  uart_dout;
  logic        uart_dout_valid;
  logic        uart_dout_ready;

  modport master (
    output acc_en, addr, wdata, ld_st_ctrl, uart_din_ready, uart_dout, uart_dout_valid,
    input  rdata, uart_din, uart_din_valid, uart_dout_ready
  );

  modport slave (
    input  acc_en, addr, wdata, ld_st_ctrl, uart_din_ready, uart_dout, uart_dout_valid,
    output rdata, uart_din, uart_din_valid, uart_dout_ready
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; full/empty gate push/pop, flush overrides both.
module sync_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CntW-1:0]  count
);
  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end
endmodule

// File: rtl/uart_mmio_fifo.sv
// Memory-mapped UART front end: address decode, sticky error flags and load mux
// around buffered TX and RX FIFOs.
module uart_mmio_fifo
  import uart_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned TX_DEPTH  = 8,
  parameter int unsigned RX_DEPTH  = 8
) (
  input logic        clk,
  input logic        rst_n,
  uart_mmio_if.slave bus
);
  localparam int unsigned TxCntW = $clog2(TX_DEPTH + 1);
  localparam int unsigned RxCntW = $clog2(RX_DEPTH + 1);

  logic              store, load;
  logic              wr_tx, rd_rx, wr_ctrl;
  logic              clr_flags, flush_tx, flush_rx;
  logic              tx_full, tx_empty, rx_full, rx_empty;
  logic [TxCntW-1:0] tx_count;
  logic [RxCntW-1:0] rx_count;
  logic [7:0]        tx_head, rx_head;
  logic              tx_ovf_q, tx_ovf_d, rx_unf_q, rx_unf_d;
  logic [31:0]       rdata;
  logic              unused_wdata;

  assign store   = is_store(bus.ld_st_ctrl);
  assign load    = ~store;
  assign wr_tx   = bus.acc_en & store & (bus.addr == BASE_ADDR + OFF_TX_DATA);
  assign rd_rx   = bus.acc_en & load  & (bus.addr == BASE_ADDR + OFF_RX_DATA);
  assign wr_ctrl = bus.acc_en & store & (bus.addr == BASE_ADDR + OFF_CTRL);

  assign clr_flags = wr_ctrl & bus.wdata[CTRL_CLR_FLAGS];
  assign flush_tx  = wr_ctrl & bus.wdata[CTRL_FLUSH_TX];
  assign flush_rx  = wr_ctrl & bus.wdata[CTRL_FLUSH_RX];

  assign unused_wdata = ^bus.wdata[31:8];

  sync_fifo #(.DEPTH(TX_DEPTH), .WIDTH(8)) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (wr_tx),
    .pop   (bus.uart_din_ready),
    .flush (flush_tx),
    .din   (bus.wdata[7:0]),
    .dout  (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  sync_fifo #(.DEPTH(RX_DEPTH), .WIDTH(8)) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bus.uart_dout_valid),
    .pop   (rd_rx),
    .flush (flush_rx),
    .din   (bus.uart_dout),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  assign bus.uart_din        = tx_head;
  assign bus.uart_din_valid  = ~tx_empty;
  assign bus.uart_dout_ready = ~rx_full;

  // A new error in the same cycle as a clear keeps the flag set.
  always_comb begin
    tx_ovf_d = (wr_tx & tx_full) | (tx_ovf_q & ~clr_flags);
    rx_unf_d = (rd_rx & rx_empty) | (rx_unf_q & ~clr_flags);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_ovf_q <= 1'b0;
      rx_unf_q <= 1'b0;
    end else begin
      tx_ovf_q <= tx_ovf_d;
      rx_unf_q <= rx_unf_d;
    end
  end

  always_comb begin
    rdata = '0;
    case (bus.addr)
      BASE_ADDR + OFF_TX_RDY:  rdata = {31'd0, ~tx_full};
      BASE_ADDR + OFF_RX_VLD:  rdata = {31'd0, ~rx_empty};
      BASE_ADDR + OFF_RX_DATA: rdata = rx_empty ? 32'd0 : {24'd0, rx_head};
      BASE_ADDR + OFF_STATUS:  rdata = {rx_unf_q, tx_ovf_q, 6'd0, 8'(rx_count), 8'(tx_count), 8'd0};
      default:                 rdata = '0;
    endcase
  end

  assign bus.rdata = rdata;
endmodule

// File: tb/tb_uart_mmio_fifo.sv
// Scoreboard bench for uart_mmio_fifo: the driver updates a queue-based model and
// posts expectations; a negedge monitor compares them against the DUT.
module tb_uart_mmio_fifo;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int TXD = 8;
  localparam int RXD = 8;
  localparam logic [31:0] A_TXRDY  = BASE + 32'h00;
  localparam logic [31:0] A_RXVLD  = BASE + 32'h04;
  localparam logic [31:0] A_TXDATA = BASE + 32'h08;
  localparam logic [31:0] A_RXDATA = BASE + 32'h0C;
  localparam logic [31:0] A_STATUS = BASE + 32'h10;
  localparam logic [31:0] A_CTRL   = BASE + 32'h14;
  localparam logic [2:0]  LW = 3'b010;
  localparam logic [2:0]  SB = 3'b101;

  logic clk = 1'b0;
  logic rst_n;

  initial forever #5 clk = ~clk;

  uart_mmio_if bus ();

  uart_mmio_fifo #(.BASE_ADDR(BASE), .TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [31:0] rd;
    logic        vld;
    logic        rdy;
  } cyc_exp_t;

  int checks = 0;
  int errors = 0;

  byte unsigned tx_q[$];
  byte unsigned rx_q[$];
  byte unsigned exp_tx[$];
  cyc_exp_t     exp_cyc[$];
  logic         m_ovf = 1'b0;
  logic         m_unf = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [31:0] model_rdata(input logic [31:0] a);
    logic [31:0] r;
    r = 32'd0;
    if (a == A_TXRDY)       r = {31'd0, tx_q.size() != TXD};
    else if (a == A_RXVLD)  r = {31'd0, rx_q.size() != 0};
    else if (a == A_RXDATA) r = (rx_q.size() == 0) ? 32'd0 : {24'd0, rx_q[0]};
    else if (a == A_STATUS) r = {m_unf, m_ovf, 6'd0, 8'(rx_q.size()), 8'(tx_q.size()), 8'd0};
    return r;
  endfunction

  // One bus cycle: drive inputs, post expectations from the pre-edge model, advance model.
  task automatic cyc(input logic en, input logic [31:0] a, input logic [31:0] wd,
                     input logic [2:0] ls, input logic rdy, input logic dv,
                     input logic [7:0] db);
    bit st, txf, rxe, rxf, hs, wr_tx, rd_rx, wr_ct, clr, ftx, frx;
    byte unsigned h;
    cyc_exp_t e;
    @(posedge clk);
    #1;
    bus.acc_en          = en;
    bus.addr            = a;
    bus.wdata           = wd;
    bus.ld_st_ctrl      = ls;
    bus.uart_din_ready  = rdy;
    bus.uart_dout_valid = dv;
    bus.uart_dout       = db;

    st  = ls[2] & (ls[1] | ls[0]);
    txf = (tx_q.size() == TXD);
    rxe = (rx_q.size() == 0);
    rxf = (rx_q.size() == RXD);
    hs  = rdy && (tx_q.size() != 0);
    e   = '{model_rdata(a), tx_q.size() != 0, !rxf};
    exp_cyc.push_back(e);

    wr_tx = en && st && (a == A_TXDATA);
    rd_rx = en && !st && (a == A_RXDATA);
    wr_ct = en && st && (a == A_CTRL);
    clr   = wr_ct && wd[0];
    ftx   = wr_ct && wd[1];
    frx   = wr_ct && wd[2];

    if (ftx) begin
      // The head byte handed over this cycle still leaves; everything behind it is lost.
      h = hs ? exp_tx[0] : 8'd0;
      tx_q.delete();
      exp_tx.delete();
      if (hs) exp_tx.push_back(h);
    end else begin
      if (hs) void'(tx_q.pop_front());
      if (wr_tx && !txf) begin
        tx_q.push_back(wd[7:0]);
        exp_tx.push_back(wd[7:0]);
      end
    end
    m_ovf = (wr_tx && txf) || (m_ovf && !clr);

    if (frx) rx_q.delete();
    else begin
      if (rd_rx && !rxe) void'(rx_q.pop_front());
      if (dv && !rxf) rx_q.push_back(db);
    end
    m_unf = (rd_rx && rxe) || (m_unf && !clr);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cyc(1'b0, 32'd0, 32'd0, LW, rdy, 1'b0, 8'd0);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] wd, input logic rdy);
    cyc(1'b1, a, wd, SB, rdy, 1'b0, 8'd0);
  endtask

  task automatic load(input logic [31:0] a);
    cyc(1'b1, a, 32'd0, LW, 1'b0, 1'b0, 8'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    bus.acc_en          = 1'b0;
    bus.ld_st_ctrl      = LW;
    bus.uart_din_ready  = 1'b0;
    bus.uart_dout_valid = 1'b0;
    bus.addr            = A_TXRDY;
    rst_n               = 1'b0;
    #1;
    check("rst_din_valid", {31'd0, bus.uart_din_valid}, 32'd0);
    check("rst_dout_ready", {31'd0, bus.uart_dout_ready}, 32'd1);
    check("rst_din", {24'd0, bus.uart_din}, 32'd0);
    check("rst_tx_rdy", bus.rdata, 32'd1);
    bus.addr = A_STATUS;
    #1;
    check("rst_status", bus.rdata, 32'd0);
    tx_q.delete();
    rx_q.delete();
    exp_tx.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: compares every driven cycle and every TX handshake against the scoreboard.
  initial begin
    cyc_exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && exp_cyc.size() > 0) begin
        e = exp_cyc.pop_front();
        check("rdata", bus.rdata, e.rd);
        check("din_valid", {31'd0, bus.uart_din_valid}, {31'd0, e.vld});
        check("dout_ready", {31'd0, bus.uart_dout_ready}, {31'd0, e.rdy});
        if (bus.uart_din_valid === 1'b1 && bus.uart_din_ready === 1'b1) begin
          if (exp_tx.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tx_byte: got %h expected no byte at %0t", bus.uart_din, $time);
          end else begin
            check("tx_byte", {24'd0, bus.uart_din}, {24'd0, exp_tx.pop_front()});
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, wd;
    int k;
    bus.acc_en          = 1'b0;
    bus.addr            = 32'd0;
    bus.wdata           = 32'd0;
    bus.ld_st_ctrl      = LW;
    bus.uart_din_ready  = 1'b0;
    bus.uart_dout_valid = 1'b0;
    bus.uart_dout       = 8'd0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    do_reset();

    // Reset-state reads.
    load(A_TXRDY);
    load(A_RXVLD);
    load(A_STATUS);

    // Three bytes buffered, then streamed out in order.
    store(A_TXDATA, 32'h41, 1'b0);
    store(A_TXDATA, 32'h42, 1'b0);
    store(A_TXDATA, 32'h43, 1'b0);
    load(A_STATUS);
    idle(5, 1'b1);

    // TX overflow and sticky-flag clear.
    for (int i = 0; i < TXD; i++) store(A_TXDATA, 32'h60 + i, 1'b0);
    store(A_TXDATA, 32'hFF, 1'b0);
    load(A_STATUS);
    load(A_TXRDY);
    store(A_CTRL, 32'h1, 1'b0);
    load(A_STATUS);
    idle(TXD + 2, 1'b1);

    // RX fill, pop from full, then one more byte.
    for (int i = 0; i < RXD; i++) cyc(1'b0, A_RXVLD, 32'd0, LW, 1'b0, 1'b1, 8'h10 + 8'(i));
    load(A_RXDATA);
    cyc(1'b0, A_STATUS, 32'd0, LW, 1'b0, 1'b1, 8'h18);
    for (int i = 0; i < RXD + 1; i++) load(A_RXDATA);

    // Underflow: ungated access has no effect, gated access sets the flag.
    cyc(1'b0, A_RXDATA, 32'd0, LW, 1'b0, 1'b0, 8'd0);
    load(A_STATUS);
    load(A_RXDATA);
    load(A_STATUS);
    store(A_CTRL, 32'h1, 1'b0);

    // TX flush while the transmitter is ready.
    for (int i = 0; i < 4; i++) store(A_TXDATA, 32'hA0 + i, 1'b0);
    store(A_CTRL, 32'h2, 1'b1);
    load(A_STATUS);
    idle(2, 1'b1);

    // Reset with both FIFOs holding data.
    for (int i = 0; i < 3; i++) cyc(1'b1, A_TXDATA, 32'hC0 + i, SB, 1'b0, 1'b1, 8'h30 + 8'(i));
    do_reset();
    load(A_STATUS);

    // Random traffic: first half leans on full TX/RX, second half on empty.
    for (int n = 0; n < 3000; n++) begin
      k = $urandom_range(0, 9);
      if (k < 6)       a = BASE + 32'(4 * k);
      else if (k < 8)  a = A_TXDATA;
      else if (k == 8) a = BASE + 32'h18;
      else             a = $urandom;
      wd = $urandom;
      if (a == A_CTRL && $urandom_range(0, 3) != 0) wd = wd & ~32'h6;
      if (n < 1500)
        cyc($urandom_range(0, 4) != 0, a, wd, 3'($urandom_range(0, 7)),
            $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1, 8'($urandom));
      else
        cyc($urandom_range(0, 4) != 0, a, wd, 3'($urandom_range(0, 7)),
            $urandom_range(0, 9) != 0, $urandom_range(0, 4) == 0, 8'($urandom));
    end

    idle(TXD + 4, 1'b1);
    idle(1, 1'b0);
    @(negedge clk);
    #1;
    check("tx_drained", exp_tx.size(), 32'd0);
    check("cycles_checked", exp_cyc.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
